palette_lut: RTL and testbench
==============================

Name: palette_lut

Overview:
- Programmable colour look-up table for the sprite/background render path. Replaces fixed 16-entry palette ROMs.
- Maps a pixel index to RGB through a writable register-file palette. Reset contents come from a package default.
- Adds a 2-stage registered lookup, a transparent-index flag and a frame-timed fade-in/fade-out engine.
- Sits between the sprite/background address stage and the VGA output mux.

Parameters:
- INDEX_W, 4, pixel index width. Depth NUM_ENTRIES = 2**INDEX_W.
- COLOR_W, 4, bits per colour channel.
- TRANSPARENT_IDX, 0, index flagged as transparent on output.
- FADE_DIV, 4, frames per fade step. Must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_valid_i  in  1  lookup request qualifier.
- pix_index_i  in  INDEX_W  palette index to look up.
- wr_en_i  in  1  palette write strobe.
- wr_addr_i  in  INDEX_W  palette entry to write.
- wr_data_i  in  3*COLOR_W  {red, green, blue} to store.
- frame_tick_i  in  1  one-cycle pulse per frame (vsync start).
- fade_mode_i  in  2  FADE_HOLD / FADE_OUT / FADE_IN (package enum).
- pix_valid_o  out  1  output qualifier.
- red_o, green_o, blue_o  out  COLOR_W each  faded colour.
- transparent_o  out  1  output pixel index equals TRANSPARENT_IDX.
- fade_level_o  out  COLOR_W  current fade level.
- fade_done_o  out  1  fade target reached.

Behaviour:
- Reset (async, rst_n low):
  - Palette loads DEFAULT_PALETTE (entries beyond package table length load 0).
  - pix_valid_o=0; red/green/blue_o=0; transparent_o=0.
  - fade_level_o=0; fade_done_o=1; fade divider=0.
  - Reset mid-fade or mid-lookup discards everything in flight.
- Lookup pipeline, fixed 2-cycle latency:
  - Stage 1 registers the palette entry, transparent flag and valid.
  - Stage 2 applies fade and registers the outputs.
  - Request at cycle N appears at N+2. One request per cycle, no stall, no backpressure.
  - Colour outputs update only when the stage is valid and otherwise hold their last value. pix_valid_o is the pipelined qualifier.
- Write port:
  - wr_en_i updates the entry at the clock edge.
  - Same-cycle lookup of the address being written returns wr_data_i (write-first forwarding).
  - A lookup one cycle later sees the new value naturally.
  - Writes to different addresses do not disturb lookups.
- Fade arithmetic:
  - Per channel, out = (c > level) ? c - level : 0 (saturating subtract, COLOR_W wide).
  - level=0 passes colour unchanged. level=2**COLOR_W-1 gives black.
- Fade engine (state = fade_mode_i, sampled each cycle):
  - Divider counts frame_tick_i pulses 0..FADE_DIV-1.
  - On the tick where the divider is FADE_DIV-1, the divider returns to 0 and level steps:
    - FADE_OUT: +1, saturating at max.
    - FADE_IN: -1, saturating at 0.
    - FADE_HOLD: no step, divider frozen.
  - Any change of fade_mode_i clears the divider in that cycle. A tick arriving in the same cycle is ignored.
  - fade_done_o, registered:
    - 1 in HOLD.
    - 1 in FADE_OUT when level==max.
    - 1 in FADE_IN when level==0.
    - 0 otherwise.
  - A level change affects pixels in stage 2 from the next cycle. No per-pixel glitch within a cycle.
- Encoding 2'b11 is reserved and behaves as FADE_HOLD.

Decomposition:
- Package palette_pkg holds:
  - fade_mode_t enum: FADE_HOLD=0, FADE_OUT=1, FADE_IN=2.
  - rgb_t packed struct {r, g, b}.
  - DEFAULT_PALETTE constant array of 16 rgb_t.
  - function sat_sub for the per-channel fade subtract.
- One sub-module, palette_fade_ctrl: divider, level register, done flag. Instanced once.
- Palette storage and the pipeline stay in palette_lut.

Test Plan:
- Reset, then index 5 valid at cycle N -> at N+2 RGB = DEFAULT_PALETTE[5], pix_valid_o=1, transparent_o=0. Index 0 -> transparent_o=1.
- Write entry 3 = 12'hABC while looking up index 3 in the same cycle -> output two cycles later = A,B,C. Back-to-back indices 2,3,4 -> three consecutive valid outputs in order.
- FADE_OUT with FADE_DIV=4, entry (F,7,0), 8 ticks -> level 2, output (D,5,0). After 60 ticks -> level F, output (0,0,0), fade_done_o=1.
- From level F, switch to FADE_IN in the same cycle as a tick -> that tick is ignored. Level reaches 0 after 60 further ticks, then fade_done_o=1.
- Assert rst_n low mid-fade with pixels in flight -> outputs go to 0 immediately (async). Palette contents return to default, fade_level_o=0.
- fade_mode_i=2'b11 with ticks -> level unchanged, fade_done_o=1.

Source files
------------

// File: rtl/palette_pkg.sv
// palette_pkg: shared types, default palette and fade helper for the palette LUT
package palette_pkg;

    typedef enum logic [1:0] {
        FADE_HOLD = 2'd0,
        FADE_OUT  = 2'd1,
        FADE_IN   = 2'd2
    } fade_mode_t;

    localparam int PKG_CW  = 4;
    localparam int PAL_LEN = 16;
    localparam int SAT_W   = 16;

    typedef struct packed {
        logic [PKG_CW-1:0] r;
        logic [PKG_CW-1:0] g;
        logic [PKG_CW-1:0] b;
    } rgb_t;

    localparam rgb_t DEFAULT_PALETTE [PAL_LEN] = '{
        12'h000, 12'hFFF, 12'hF00, 12'h0F0,
        12'h00F, 12'hFF0, 12'h0FF, 12'hF0F,
        12'h888, 12'hF70, 12'h444, 12'h8F8,
        12'h88F, 12'hF88, 12'h0A5, 12'hCCC
    };

    // Saturating per-channel subtract; callers zero-extend to SAT_W and truncate back.
    function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] c, input logic [SAT_W-1:0] level);
        return (c > level) ? c - level : '0;
    endfunction

endpackage

// File: rtl/palette_fade_ctrl.sv
// palette_fade_ctrl: frame-timed fade level engine with divider and done flag
module palette_fade_ctrl
    import palette_pkg::*;
#(
    parameter int COLOR_W  = 4,
    parameter int FADE_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick_i,
    input  logic [1:0]         fade_mode_i,
    output logic [COLOR_W-1:0] level_o,
    output logic               done_o
);

    localparam int DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [COLOR_W-1:0] LEVEL_MAX = '1;

    logic [DIV_W-1:0]   div_q, div_d;
    logic [COLOR_W-1:0] level_q, level_d;
    logic               done_q, done_d;
    logic [1:0]         mode_q;
    logic               changed, fading, wrap;

    // Next divider/level/done; a mode change swallows any tick in the same cycle.
    always_comb begin
        changed = fade_mode_i != mode_q;
        fading  = (fade_mode_i == FADE_OUT) || (fade_mode_i == FADE_IN);
        wrap    = div_q == DIV_W'(FADE_DIV - 1);
        div_d   = changed ? '0 : (frame_tick_i && fading) ? (wrap ? '0 : div_q + 1'b1) : div_q;
        level_d = level_q;
        if (!changed && frame_tick_i && wrap) begin
            if (fade_mode_i == FADE_OUT && level_q != LEVEL_MAX) level_d = level_q + 1'b1;
            if (fade_mode_i == FADE_IN && level_q != '0) level_d = level_q - 1'b1;
        end
        done_d = (fade_mode_i == FADE_OUT) ? (level_d == LEVEL_MAX) :
                 (fade_mode_i == FADE_IN)  ? (level_d == '0) : 1'b1;
    end

    // Fade state registers; reset leaves the engine idle at full brightness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            level_q <= '0;
            done_q  <= 1'b1;
            mode_q  <= FADE_HOLD;
        end else begin
            div_q   <= div_d;
            level_q <= level_d;
            done_q  <= done_d;
            mode_q  <= fade_mode_i;
        end
    end

    assign level_o = level_q;
    assign done_o  = done_q;

endmodule

// File: rtl/palette_lut.sv
// palette_lut: writable colour palette with 2-stage lookup, transparency flag and fade
module palette_lut
    import palette_pkg::*;
#(
    parameter int INDEX_W         = 4,
    parameter int COLOR_W         = 4,
    parameter int TRANSPARENT_IDX = 0,
    parameter int FADE_DIV        = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pix_valid_i,
    input  logic [INDEX_W-1:0]   pix_index_i,
    input  logic                 wr_en_i,
    input  logic [INDEX_W-1:0]   wr_addr_i,
    input  logic [3*COLOR_W-1:0] wr_data_i,
    input  logic                 frame_tick_i,
    input  logic [1:0]           fade_mode_i,
    output logic                 pix_valid_o,
    output logic [COLOR_W-1:0]   red_o,
    output logic [COLOR_W-1:0]   green_o,
    output logic [COLOR_W-1:0]   blue_o,
    output logic                 transparent_o,
    output logic [COLOR_W-1:0]   fade_level_o,
    output logic                 fade_done_o
);

    localparam int NUM_ENTRIES = 2 ** INDEX_W;
    localparam int RGB_W       = 3 * COLOR_W;

    logic [RGB_W-1:0]   pal_q [NUM_ENTRIES];
    logic [RGB_W-1:0]   rd_d, s1_rgb_q;
    logic               s1_valid_q, s1_transp_q;
    logic [COLOR_W-1:0] level;
    logic [COLOR_W-1:0] red_d, green_d, blue_d, red_q, green_q, blue_q;
    logic               valid_q, transp_q;

    // Default entry widened/narrowed to the configured channel width; entries past the table are black.
    function automatic logic [RGB_W-1:0] reset_entry(input int i);
        rgb_t d;
        d = (i < PAL_LEN) ? DEFAULT_PALETTE[i] : '0;
        return {COLOR_W'(d.r), COLOR_W'(d.g), COLOR_W'(d.b)};
    endfunction

    palette_fade_ctrl #(.COLOR_W(COLOR_W), .FADE_DIV(FADE_DIV)) u_fade (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick_i (frame_tick_i),
        .fade_mode_i  (fade_mode_i),
        .level_o      (level),
        .done_o       (fade_done_o)
    );

    // Palette register file, reloaded from the package default on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) pal_q[i] <= reset_entry(i);
        end else if (wr_en_i) begin
            pal_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read with write-first forwarding, then fade the stage-1 colour per channel.
    always_comb begin
        rd_d    = (wr_en_i && wr_addr_i == pix_index_i) ? wr_data_i : pal_q[pix_index_i];
        red_d   = COLOR_W'(sat_sub(SAT_W'(s1_rgb_q[RGB_W-1 -: COLOR_W]), SAT_W'(level)));
        green_d = COLOR_W'(sat_sub(SAT_W'(s1_rgb_q[2*COLOR_W-1 -: COLOR_W]), SAT_W'(level)));
        blue_d  = COLOR_W'(sat_sub(SAT_W'(s1_rgb_q[COLOR_W-1:0]), SAT_W'(level)));
    end

    // Stage 1: capture palette entry and transparency for valid requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_rgb_q    <= '0;
            s1_transp_q <= 1'b0;
        end else begin
            s1_valid_q <= pix_valid_i;
            if (pix_valid_i) begin
                s1_rgb_q    <= rd_d;
                s1_transp_q <= pix_index_i == INDEX_W'(TRANSPARENT_IDX);
            end
        end
    end

    // Stage 2: register faded colour; outputs hold when the stage is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            transp_q <= 1'b0;
        end else begin
            valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                red_q    <= red_d;
                green_q  <= green_d;
                blue_q   <= blue_d;
                transp_q <= s1_transp_q;
            end
        end
    end

    assign pix_valid_o   = valid_q;
    assign red_o         = red_q;
    assign green_o       = green_q;
    assign blue_o        = blue_q;
    assign transparent_o = transp_q;
    assign fade_level_o  = level;

endmodule

// File: tb/tb_palette_lut.sv
// tb_palette_lut: directed self-checking bench for palette_lut
module tb_palette_lut;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic [3:0]  pix_index = '0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic        frame_tick = 1'b0;
    logic [1:0]  fade_mode = 2'b00;
    logic        pix_valid_o, transparent_o, fade_done_o;
    logic [3:0]  red_o, green_o, blue_o, fade_level_o;
    logic [11:0] rgb;

    int total = 0;
    int passed = 0;

    assign rgb = {red_o, green_o, blue_o};

    palette_lut #(.INDEX_W(4), .COLOR_W(4), .TRANSPARENT_IDX(0), .FADE_DIV(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pix_valid_i   (pix_valid),
        .pix_index_i   (pix_index),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .frame_tick_i  (frame_tick),
        .fade_mode_i   (fade_mode),
        .pix_valid_o   (pix_valid_o),
        .red_o         (red_o),
        .green_o       (green_o),
        .blue_o        (blue_o),
        .transparent_o (transparent_o),
        .fade_level_o  (fade_level_o),
        .fade_done_o   (fade_done_o)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic lookup(input logic [3:0] idx);
        pix_valid = 1'b1;
        pix_index = idx;
        cyc();
        pix_valid = 1'b0;
        cyc();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            cyc();
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 16'(pix_valid_o), 16'h0);
        chk("rst_rgb", 16'(rgb), 16'h000);
        chk("rst_transp", 16'(transparent_o), 16'h0);
        chk("rst_level", 16'(fade_level_o), 16'h0);
        chk("rst_done", 16'(fade_done_o), 16'h1);
        rst_n = 1'b1;
        cyc();

        lookup(4'd5);
        chk("idx5_rgb", 16'(rgb), 16'hFF0);
        chk("idx5_valid", 16'(pix_valid_o), 16'h1);
        chk("idx5_transp", 16'(transparent_o), 16'h0);
        cyc();
        chk("idle_valid", 16'(pix_valid_o), 16'h0);
        chk("idle_hold_rgb", 16'(rgb), 16'hFF0);
        lookup(4'd0);
        chk("idx0_transp", 16'(transparent_o), 16'h1);
        chk("idx0_rgb", 16'(rgb), 16'h000);

        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 12'hABC;
        pix_valid = 1'b1; pix_index = 4'd3;
        cyc();
        wr_en = 1'b0; pix_valid = 1'b0;
        cyc();
        chk("fwd_idx3", 16'(rgb), 16'hABC);

        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 12'h123;
        pix_valid = 1'b1; pix_index = 4'd6;
        cyc();
        wr_en = 1'b0; pix_valid = 1'b0;
        cyc();
        chk("other_addr_idx6", 16'(rgb), 16'h0FF);
        lookup(4'd7);
        chk("new_idx7", 16'(rgb), 16'h123);

        pix_valid = 1'b1; pix_index = 4'd2;
        cyc();
        pix_index = 4'd3;
        cyc();
        chk("b2b_0", 16'({pix_valid_o, rgb}), 16'h1F00);
        pix_index = 4'd4;
        cyc();
        chk("b2b_1", 16'({pix_valid_o, rgb}), 16'h1ABC);
        pix_valid = 1'b0;
        cyc();
        chk("b2b_2", 16'({pix_valid_o, rgb}), 16'h100F);
        cyc();
        chk("b2b_end", 16'(pix_valid_o), 16'h0);

        fade_mode = 2'd1;
        cyc();
        ticks(8);
        chk("out8_level", 16'(fade_level_o), 16'h2);
        chk("out8_done", 16'(fade_done_o), 16'h0);
        lookup(4'd9);
        chk("out8_rgb", 16'(rgb), 16'hD50);
        ticks(51);
        chk("out59_level", 16'(fade_level_o), 16'hE);
        chk("out59_done", 16'(fade_done_o), 16'h0);
        ticks(1);
        chk("out60_level", 16'(fade_level_o), 16'hF);
        chk("out60_done", 16'(fade_done_o), 16'h1);
        lookup(4'd9);
        chk("out60_rgb", 16'(rgb), 16'h000);

        fade_mode = 2'd2;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
        chk("in_switch_level", 16'(fade_level_o), 16'hF);
        chk("in_switch_done", 16'(fade_done_o), 16'h0);
        ticks(59);
        chk("in59_level", 16'(fade_level_o), 16'h1);
        chk("in59_done", 16'(fade_done_o), 16'h0);
        ticks(1);
        chk("in60_level", 16'(fade_level_o), 16'h0);
        chk("in60_done", 16'(fade_done_o), 16'h1);
        lookup(4'd9);
        chk("in60_rgb", 16'(rgb), 16'hF70);

        fade_mode = 2'd1;
        cyc();
        ticks(8);
        chk("refade_level", 16'(fade_level_o), 16'h2);
        fade_mode = 2'd3;
        ticks(8);
        chk("rsvd_level", 16'(fade_level_o), 16'h2);
        chk("rsvd_done", 16'(fade_done_o), 16'h1);

        fade_mode = 2'd1;
        lookup(4'd9);
        chk("pre_rst_rgb", 16'(rgb), 16'hD50);
        pix_valid = 1'b1; pix_index = 4'd9;
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 16'(pix_valid_o), 16'h0);
        chk("async_rgb", 16'(rgb), 16'h000);
        chk("async_level", 16'(fade_level_o), 16'h0);
        chk("async_done", 16'(fade_done_o), 16'h1);
        pix_valid = 1'b0;
        fade_mode = 2'd0;
        cyc();
        rst_n = 1'b1;
        cyc();
        lookup(4'd3);
        chk("rst_pal_idx3", 16'(rgb), 16'h0F0);
        lookup(4'd7);
        chk("rst_pal_idx7", 16'(rgb), 16'hF0F);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
